core_port_arbiter: RTL and testbench
====================================

// Module: core_port_arbiter
// PURPOSE
//  Shares a single simple core port (req valid/ready/addr, resp valid/data) between N
//  upstream requesters, typically several cpu_translator instances. Round-robin grant,
//  exactly one transaction outstanding on the core port.
//  Routes each core response back to the requester that issued it.
//  Response timeout converts a hung core access into an error response.
// PARAMETERS
//  N_REQ     4            number of upstream requesters (>=2)
//  AW        32           address width
//  DW        32           data width
//  TIMEOUT   64           max cycles in WAIT before error completion; 0 disables timeout
//  ERR_DATA  32'hDEADBEEF data returned on a timeout completion
// PORTS
//  clk            in   1         clock, all logic on rising edge
//  rst_n          in   1         synchronous active-low reset
//  up_req_valid   in   N_REQ     per-requester request valid
//  up_req_ready   out  N_REQ     per-requester accept, one-hot or zero
//  up_req_addr    in   N_REQ*AW  flattened addresses, requester i at [i*AW +: AW]
//  up_resp_valid  out  N_REQ     one-hot response pulse to the owning requester
//  up_resp_data   out  DW        response data, shared, valid with up_resp_valid
//  up_resp_err    out  1         1 = timeout completion, qualifies up_resp_valid
//  core_req_valid out  1         request to core
//  core_req_ready in   1         core accepts request
//  core_req_addr  out  AW        latched granted address
//  core_resp_valid in  1         core response pulse
//  core_resp_data in   DW        core response data
//  busy           out  1         state != IDLE
//  grant_id       out  $clog2(N_REQ)  owner of current or last transaction
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, all outputs 0, rr_ptr=0, timeout counter=0.
//  Reset mid-transaction abandons it; a later core_resp_valid falls in IDLE and is dropped.
//  FSM IDLE -> REQ -> WAIT -> IDLE:
//   IDLE: if any up_req_valid, winner = first set bit scanning from rr_ptr upward (modulo N_REQ).
//    up_req_ready[winner]=1 combinationally this cycle, all other ready bits 0.
//    Latch addr and grant_id, rr_ptr<=winner+1 (wraps to 0 at N_REQ), go to REQ.
//    No valid: stay in IDLE.
//   REQ: core_req_valid=1 with stable core_req_addr until core_req_ready.
//    On handshake go to WAIT, clear the counter.
//    If core_resp_valid arrives in the same cycle as the handshake, complete directly
//    (registered resp next cycle) and go to IDLE.
//   WAIT: core_req_valid=0, counter increments each cycle.
//    On core_resp_valid: register data and pulse up_resp_valid[grant_id] with err=0, go to IDLE.
//    If TIMEOUT!=0 and counter==TIMEOUT-1 with no resp: pulse resp with data=ERR_DATA,
//    err=1, go to IDLE.
//  core_resp_valid in IDLE or REQ (before the handshake) is ignored.
//  up_resp_valid/data/err are registered, 1 cycle after core_resp_valid, single-cycle pulse.
//  The cycle up_resp_valid pulses, state is already IDLE and may grant a new request.
//  Latency: up accept at T, core_req_valid at T+1, core resp at R, up_resp_valid at R+1.
//  Requester must hold up_req_valid/addr until its ready bit is seen.
//  A requester dropping valid before grant is simply skipped.
//  Fairness: with all N_REQ requesting continuously, grants cycle 0,1,..,N_REQ-1,0.
//  Each requester waits at most N_REQ-1 transactions.
//  Counter width $clog2(TIMEOUT+1), saturates, never wraps.
//  Address is latched at accept, so later up_req_addr changes do not affect core_req_addr.
// STRUCTURE
//  Package core_port_pkg holds:
//   typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_e;
//   localparam ARB_ERR_DATA.
//  Sub-module rr_pick #(N): inputs req vector and ptr; outputs one-hot grant,
//  index and any-flag; purely combinational double-width masked priority scan.
//  Top level holds the FSM, latches, counter and response register.
// TESTING
//  1 Single requester: req1 addr 0x5, core ready at once, resp 0xCAFE0001 after 3 cycles
//    -> core_req_addr=0x5 for 1 cycle, up_resp_valid=4'b0010, data 0xCAFE0001, err=0.
//  2 All 4 valid continuously, distinct addrs 0x10..0x13, core resp 2 cycles
//    -> grant order 0,1,2,3,0, each up_resp_valid one-hot to the matching owner.
//  3 core_req_ready held low 5 cycles -> core_req_valid and addr stable 5 cycles,
//    no up_req_ready bits set meanwhile.
//  4 TIMEOUT=8, core never responds -> up_resp_valid at WAIT entry+8, data 0xDEADBEEF,
//    err=1. A late core_resp_valid is dropped, no up_resp pulse.
//  5 rst_n low in WAIT, resp arrives after reset -> all outputs 0, no up_resp_valid,
//    next grant goes to requester 0.
//  6 core_resp_valid in the same cycle as core_req_ready -> one up_resp_valid, next cycle, err=0.

Source files
------------

// File: rtl/core_port_pkg.sv
// Shared types and constants for the core port arbiter.
// Arbiter FSM states and the default data returned when a core access times out.
package core_port_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_e;

    localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/core_port_arbiter_rr_pick.sv
// Round-robin picker: first requester at or above ptr, wrapping around to bit 0.
// The request vector is duplicated so the wrap-around becomes a plain lowest-bit scan.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    // Low half holds only candidates at or above ptr; high half holds the wrapped-around ones.
    assign dbl = {req, req & mask};
    assign any = |req;

    always_comb begin : scan
        logic found;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (dbl[i] && !found) begin
                found        = 1'b1;
                grant[i % N] = 1'b1;
                idx          = IW'(i % N);
            end
        end
    end

endmodule

// File: rtl/core_port_arbiter.sv
// Shares one core port among N_REQ requesters with round-robin grant,
// a single outstanding transaction, response routing and a response timeout.
module core_port_arbiter
    import core_port_pkg::*;
#(
    parameter int              N_REQ    = 4,
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter int              TIMEOUT  = 64,
    parameter logic [DW-1:0]   ERR_DATA = DW'(ARB_ERR_DATA)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           up_req_valid,
    output logic [N_REQ-1:0]           up_req_ready,
    input  logic [N_REQ*AW-1:0]        up_req_addr,
    output logic [N_REQ-1:0]           up_resp_valid,
    output logic [DW-1:0]              up_resp_data,
    output logic                       up_resp_err,
    output logic                       core_req_valid,
    input  logic                       core_req_ready,
    output logic [AW-1:0]              core_req_addr,
    input  logic                       core_resp_valid,
    input  logic [DW-1:0]              core_resp_data,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT) : {CW{1'b1}};

    arb_state_e       state, state_next;
    logic [IW-1:0]    rr_ptr;
    logic [N_REQ-1:0] owner_vec;
    logic [CW-1:0]    cnt;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    logic accept;
    logic done_ok;
    logic done_timeout;
    logic timeout_hit;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (up_req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
    assign busy        = (state != ARB_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        up_req_ready   = '0;
        core_req_valid = 1'b0;
        accept         = 1'b0;
        done_ok        = 1'b0;
        done_timeout   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    up_req_ready = pick_grant;
                    accept       = 1'b1;
                    state_next   = ARB_REQ;
                end
            end
            ARB_REQ: begin
                core_req_valid = 1'b1;
                if (core_req_ready) begin
                    // A response in the handshake cycle completes the transaction immediately.
                    if (core_resp_valid) begin
                        done_ok    = 1'b1;
                        state_next = ARB_IDLE;
                    end else begin
                        state_next = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                if (core_resp_valid) begin
                    done_ok    = 1'b1;
                    state_next = ARB_IDLE;
                end else if (timeout_hit) begin
                    done_timeout = 1'b1;
                    state_next   = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            grant_id      <= '0;
            owner_vec     <= '0;
            core_req_addr <= '0;
        end else if (accept) begin
            rr_ptr        <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            grant_id      <= pick_idx;
            owner_vec     <= pick_grant;
            core_req_addr <= up_req_addr[int'(pick_idx) * AW +: AW];
        end
    end

    // Counts cycles spent in WAIT; held at zero while requesting and saturating instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ARB_REQ) begin
            cnt <= '0;
        end else if (state == ARB_WAIT && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_resp_valid <= '0;
            up_resp_data  <= '0;
            up_resp_err   <= 1'b0;
        end else begin
            up_resp_valid <= (done_ok || done_timeout) ? owner_vec : '0;
            up_resp_data  <= done_ok ? core_resp_data : (done_timeout ? ERR_DATA : '0);
            up_resp_err   <= done_timeout;
        end
    end

endmodule

// File: tb/tb_core_port_arbiter.sv
// Self-checking bench for core_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_core_port_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      up_req_valid;
    logic [N-1:0]      up_req_ready;
    logic [N*AW-1:0]   up_req_addr;
    logic [N-1:0]      up_resp_valid;
    logic [DW-1:0]     up_resp_data;
    logic              up_resp_err;
    logic              core_req_valid;
    logic              core_req_ready;
    logic [AW-1:0]     core_req_addr;
    logic              core_resp_valid;
    logic [DW-1:0]     core_resp_data;
    logic              busy;
    logic [1:0]        grant_id;

    logic [AW-1:0]     addr_arr [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            up_req_addr[i*AW +: AW] = addr_arr[i];
        end
    end

    core_port_arbiter #(
        .N_REQ   (N),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TMO),
        .ERR_DATA(ERRD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .up_req_valid   (up_req_valid),
        .up_req_ready   (up_req_ready),
        .up_req_addr    (up_req_addr),
        .up_resp_valid  (up_resp_valid),
        .up_resp_data   (up_resp_data),
        .up_resp_err    (up_resp_err),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_addr  (core_req_addr),
        .core_resp_valid(core_resp_valid),
        .core_resp_data (core_resp_data),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        up_req_valid    = '0;
        core_req_ready  = 1'b0;
        core_resp_valid = 1'b0;
        core_resp_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int i = 0; i < N; i++) addr_arr[i] = '0;
        rst_n = 1'b0;
        step();
        step();
        sample();
        total++;
        if ({up_req_ready, up_resp_valid, up_resp_err, core_req_valid, busy, grant_id} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%h exp=0",
                     {up_req_ready, up_resp_valid, up_resp_err, core_req_valid, busy, grant_id});
        end
        total++;
        if (core_req_addr !== '0) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=0", core_req_addr); end
        total++;
        if (up_resp_data !== '0) begin bad++; $display("[TB] FAIL reset_data got=%h exp=0", up_resp_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        addr_arr[1]  = 32'h5;
        up_req_valid = 4'b0010;
        sample();
        total++;
        if (up_req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL single_ready got=%b exp=0010", up_req_ready); end
        step();
        up_req_valid   = '0;
        core_req_ready = 1'b1;
        sample();
        total++;
        if (core_req_valid !== 1'b1 || core_req_addr !== 32'h5 || grant_id !== 2'd1) begin
            bad++;
            $display("[TB] FAIL single_req got v=%b a=%h g=%0d exp v=1 a=5 g=1", core_req_valid, core_req_addr, grant_id);
        end
        step();
        core_req_ready = 1'b0;
        sample();
        total++;
        if (core_req_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_wait got v=%b busy=%b exp v=0 busy=1", core_req_valid, busy);
        end
        step();
        step();
        core_resp_valid = 1'b1;
        core_resp_data  = 32'hCAFE0001;
        sample();
        total++;
        if (up_resp_valid !== '0) begin bad++; $display("[TB] FAIL single_early_resp got=%b exp=0000", up_resp_valid); end
        step();
        idle_inputs();
        sample();
        total++;
        if (up_resp_valid !== 4'b0010 || up_resp_data !== 32'hCAFE0001 || up_resp_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_resp got v=%b d=%h e=%b busy=%b exp v=0010 d=cafe0001 e=0 busy=0",
                     up_resp_valid, up_resp_data, up_resp_err, busy);
        end
        step();
        sample();
        total++;
        if (up_resp_valid !== '0) begin bad++; $display("[TB] FAIL single_pulse_len got=%b exp=0000", up_resp_valid); end
        step();
    endtask

    task automatic test_fairness();
        logic [N-1:0] ev;
        logic [N-1:0] pv;
        do_reset();
        for (int i = 0; i < N; i++) addr_arr[i] = 32'h10 + i;
        up_req_valid = '1;
        for (int t = 0; t < 5; t++) begin
            ev = '0;
            ev[t % N] = 1'b1;
            if (t == 4) up_req_valid = '1;
            sample();
            total++;
            if (up_req_ready !== ev) begin bad++; $display("[TB] FAIL fair_grant%0d got=%b exp=%b", t, up_req_ready, ev); end
            if (t > 0) begin
                pv = '0;
                pv[(t - 1) % N] = 1'b1;
                total++;
                if (up_resp_valid !== pv || up_resp_data !== 32'hF000 + t - 1) begin
                    bad++;
                    $display("[TB] FAIL fair_resp%0d got v=%b d=%h exp v=%b d=%h", t - 1, up_resp_valid, up_resp_data, pv, 32'hF000 + t - 1);
                end
            end
            step();
            core_req_ready = 1'b1;
            sample();
            total++;
            if (core_req_valid !== 1'b1 || core_req_addr !== 32'h10 + (t % N)) begin
                bad++;
                $display("[TB] FAIL fair_addr%0d got v=%b a=%h exp v=1 a=%h", t, core_req_valid, core_req_addr, 32'h10 + (t % N));
            end
            step();
            core_req_ready = 1'b0;
            step();
            core_resp_valid = 1'b1;
            core_resp_data  = 32'hF000 + t;
            step();
            core_resp_valid = 1'b0;
            if (t == 4) up_req_valid = '0;
        end
        sample();
        total++;
        if (up_resp_valid !== 4'b0001 || up_resp_data !== 32'hF004) begin
            bad++;
            $display("[TB] FAIL fair_resp4 got v=%b d=%h exp v=0001 d=0000f004", up_resp_valid, up_resp_data);
        end
        step();
    endtask

    task automatic test_stall();
        addr_arr[2]  = 32'h2222_0000;
        up_req_valid = 4'b0100;
        sample();
        total++;
        if (up_req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL stall_grant got=%b exp=0100", up_req_ready); end
        step();
        up_req_valid = 4'b1011;
        addr_arr[2]  = 32'h9999_9999;
        for (int k = 0; k < 5; k++) begin
            sample();
            total++;
            if (core_req_valid !== 1'b1 || core_req_addr !== 32'h2222_0000 || up_req_ready !== '0) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d got v=%b a=%h rdy=%b exp v=1 a=22220000 rdy=0000",
                         k, core_req_valid, core_req_addr, up_req_ready);
            end
            step();
        end
        up_req_valid   = '0;
        core_req_ready = 1'b1;
        step();
        core_req_ready  = 1'b0;
        core_resp_valid = 1'b1;
        core_resp_data  = 32'h5A5A_0003;
        step();
        idle_inputs();
        sample();
        total++;
        if (up_resp_valid !== 4'b0100 || up_resp_data !== 32'h5A5A_0003 || up_resp_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_resp got v=%b d=%h e=%b exp v=0100 d=5a5a0003 e=0", up_resp_valid, up_resp_data, up_resp_err);
        end
        step();
    endtask

    task automatic test_timeout();
        addr_arr[0]  = 32'h0000_0A00;
        up_req_valid = 4'b0001;
        sample();
        total++;
        if (up_req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL tmo_grant got=%b exp=0001", up_req_ready); end
        step();
        up_req_valid   = '0;
        core_req_ready = 1'b1;
        step();
        core_req_ready = 1'b0;
        for (int j = 0; j < TMO; j++) begin
            sample();
            total++;
            if (up_resp_valid !== '0 || busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL tmo_wait%0d got v=%b busy=%b exp v=0000 busy=1", j, up_resp_valid, busy);
            end
            step();
        end
        sample();
        total++;
        if (up_resp_valid !== 4'b0001 || up_resp_data !== ERRD || up_resp_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tmo_resp got v=%b d=%h e=%b busy=%b exp v=0001 d=deadbeef e=1 busy=0",
                     up_resp_valid, up_resp_data, up_resp_err, busy);
        end
        step();
        core_resp_valid = 1'b1;
        core_resp_data  = 32'h1234_5678;
        step();
        core_resp_valid = 1'b0;
        sample();
        total++;
        if (up_resp_valid !== '0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tmo_late got v=%b busy=%b exp v=0000 busy=0", up_resp_valid, busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        addr_arr[2]  = 32'h0000_0B00;
        up_req_valid = 4'b0100;
        step();
        up_req_valid   = '0;
        core_req_ready = 1'b1;
        step();
        core_req_ready = 1'b0;
        sample();
        total++;
        if (busy !== 1'b1 || core_req_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_wait got busy=%b v=%b exp busy=1 v=0", busy, core_req_valid);
        end
        step();
        rst_n = 1'b0;
        step();
        rst_n           = 1'b1;
        core_resp_valid = 1'b1;
        core_resp_data  = 32'h0000_0077;
        sample();
        total++;
        if ({up_req_ready, up_resp_valid, up_resp_err, core_req_valid, busy, grant_id} !== '0 ||
            core_req_addr !== '0 || up_resp_data !== '0) begin
            bad++;
            $display("[TB] FAIL rstmid_outs got ctl=%h a=%h d=%h exp all 0",
                     {up_req_ready, up_resp_valid, up_resp_err, core_req_valid, busy, grant_id}, core_req_addr, up_resp_data);
        end
        step();
        core_resp_valid = 1'b0;
        up_req_valid    = '1;
        sample();
        total++;
        if (up_resp_valid !== '0 || up_req_ready !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL rstmid_next got v=%b rdy=%b exp v=0000 rdy=0001", up_resp_valid, up_req_ready);
        end
        do_reset();
    endtask

    task automatic test_same_cycle();
        addr_arr[3]  = 32'h0000_0C00;
        up_req_valid = 4'b1000;
        sample();
        total++;
        if (up_req_ready !== 4'b1000) begin bad++; $display("[TB] FAIL same_grant got=%b exp=1000", up_req_ready); end
        step();
        up_req_valid    = '0;
        core_req_ready  = 1'b1;
        core_resp_valid = 1'b1;
        core_resp_data  = 32'hABCD_0006;
        sample();
        total++;
        if (core_req_valid !== 1'b1 || up_resp_valid !== '0) begin
            bad++;
            $display("[TB] FAIL same_req got v=%b rv=%b exp v=1 rv=0000", core_req_valid, up_resp_valid);
        end
        step();
        idle_inputs();
        sample();
        total++;
        if (up_resp_valid !== 4'b1000 || up_resp_data !== 32'hABCD_0006 || up_resp_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL same_resp got v=%b d=%h e=%b busy=%b exp v=1000 d=abcd0006 e=0 busy=0",
                     up_resp_valid, up_resp_data, up_resp_err, busy);
        end
        step();
        sample();
        total++;
        if (up_resp_valid !== '0) begin bad++; $display("[TB] FAIL same_single got=%b exp=0000", up_resp_valid); end
        step();
    endtask

    // Transaction-level model: pending requests per requester, a rotating priority start,
    // one transaction in flight, and a per-transaction core response delay chosen up front.
    task automatic test_random();
        bit            pend [N];
        int            rrp;
        int            phase;
        int            owner;
        int            waited;
        int            dly;
        int            w;
        int            idx;
        logic [AW-1:0] cur_addr;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_rv, nxt_rv;
        logic [DW-1:0] exp_rd, nxt_rd;
        logic          exp_re, nxt_re;
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        rrp = 0; phase = 0; owner = 0; waited = 0; dly = 0;
        cur_addr = '0;
        exp_rv = '0; exp_rd = '0; exp_re = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]     = 1'b1;
                    addr_arr[i] = $urandom;
                end
                up_req_valid[i] = pend[i];
            end
            core_req_ready  = 1'b0;
            core_resp_valid = 1'b0;
            core_resp_data  = $urandom;
            if (phase == 1) begin
                core_req_ready = ($urandom_range(0, 1) == 1);
                if (core_req_ready && dly == 0) core_resp_valid = 1'b1;
            end else if (phase == 2) begin
                if (dly <= TMO && waited + 1 == dly) core_resp_valid = 1'b1;
            end
            exp_ready = '0;
            w = -1;
            if (phase == 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (rrp + k) % N;
                    if (w < 0 && pend[idx]) w = idx;
                end
                if (w >= 0) exp_ready[w] = 1'b1;
            end
            sample();
            total++;
            if (up_req_ready !== exp_ready) begin
                bad++;
                $display("[TB] FAIL rnd_ready c=%0d got=%b exp=%b", c, up_req_ready, exp_ready);
            end
            total++;
            if (core_req_valid !== (phase == 1) || busy !== (phase != 0)) begin
                bad++;
                $display("[TB] FAIL rnd_state c=%0d got v=%b busy=%b exp v=%b busy=%b",
                         c, core_req_valid, busy, phase == 1, phase != 0);
            end
            if (phase == 1) begin
                total++;
                if (core_req_addr !== cur_addr) begin
                    bad++;
                    $display("[TB] FAIL rnd_addr c=%0d got=%h exp=%h", c, core_req_addr, cur_addr);
                end
            end
            total++;
            if (up_resp_valid !== exp_rv) begin
                bad++;
                $display("[TB] FAIL rnd_resp_valid c=%0d got=%b exp=%b", c, up_resp_valid, exp_rv);
            end
            if (exp_rv != '0) begin
                total++;
                if (up_resp_data !== exp_rd || up_resp_err !== exp_re) begin
                    bad++;
                    $display("[TB] FAIL rnd_resp_data c=%0d got d=%h e=%b exp d=%h e=%b", c, up_resp_data, up_resp_err, exp_rd, exp_re);
                end
            end
            nxt_rv = '0; nxt_rd = '0; nxt_re = 1'b0;
            case (phase)
                0: if (w >= 0) begin
                    owner    = w;
                    cur_addr = addr_arr[w];
                    pend[w]  = 1'b0;
                    rrp      = (w + 1) % N;
                    dly      = $urandom_range(0, 10);
                    phase    = 1;
                end
                1: if (core_req_ready) begin
                    if (core_resp_valid) begin
                        nxt_rv[owner] = 1'b1;
                        nxt_rd        = core_resp_data;
                        phase         = 0;
                    end else begin
                        waited = 0;
                        phase  = 2;
                    end
                end
                default: begin
                    if (core_resp_valid) begin
                        nxt_rv[owner] = 1'b1;
                        nxt_rd        = core_resp_data;
                        phase         = 0;
                    end else if (waited == TMO - 1) begin
                        nxt_rv[owner] = 1'b1;
                        nxt_rd        = ERRD;
                        nxt_re        = 1'b1;
                        phase         = 0;
                    end else begin
                        waited++;
                    end
                end
            endcase
            exp_rv = nxt_rv; exp_rd = nxt_rd; exp_re = nxt_re;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_same_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
